excp_ctrl: RTL and testbench
============================

# excp_ctrl

Exception/interrupt sequencer sitting between the write-back stage and the CSR file. It detects interrupts and exceptions on the committing instruction, prioritises them into a single ecode/esubcode, drives the CSR file's exception and ertn ports, flushes the pipeline and holds a redirect request to fetch until it is accepted. Fetch reaches EENTRY on exceptions and ERA on ertn only through this block.

## Interface
- CNT_W, 16, width of the taken-exception debug counter

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  write-back stage holds a valid instruction
- wb_pc  in  32  PC of the write-back instruction
- wb_vaddr  in  32  faulting data address (ALE)
- wb_ex_vec  in  5  raw exception flags {ADEF, INE, SYS, BRK, ALE} = bits [4:0]
- wb_ertn  in  1  write-back instruction is ertn
- csr_estat_is  in  13  ESTAT.IS from the CSR file
- csr_ecfg_lie  in  13  ECFG.LIE from the CSR file
- csr_crmd_ie  in  1  CRMD.IE from the CSR file
- csr_eentry  in  32  EENTRY value
- csr_era  in  32  ERA value
- redirect_ready  in  1  fetch accepts the redirect
- csr_wb_ex  out  1  exception commit strobe to the CSR file
- csr_wb_ecode  out  6  exception code
- csr_wb_esubcode  out  9  exception subcode
- csr_wb_pc  out  32  PC recorded into ERA
- csr_wb_vaddr  out  32  address recorded into BADV
- csr_ertn_flush  out  1  ertn commit strobe to the CSR file
- pipe_flush  out  1  kill all in-flight instructions in IF..WB
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- ex_count  out  CNT_W  number of exceptions taken, wraps

## Operation
- int_pend = |(csr_estat_is & csr_ecfg_lie) & csr_crmd_ie. It is sampled combinationally each IDLE cycle.
- take_ex = IDLE & wb_valid & (int_pend | |wb_ex_vec).
- take_ertn = IDLE & wb_valid & wb_ertn & ~take_ex. An exception always beats ertn.
- Priority, highest first, gives ecode/esubcode:
  - INT: 0x00/0
  - ADEF: 0x08/0
  - INE: 0x0D/0
  - SYS: 0x0B/0
  - BRK: 0x0C/0
  - ALE: 0x09/0
- csr_wb_ex = take_ex. csr_ertn_flush = take_ertn. Both are combinational single-cycle strobes, so the CSR file updates on the same edge.
- csr_wb_pc = wb_pc. csr_wb_vaddr = wb_vaddr. Both pass through.
- When no exception is taken, csr_wb_ecode and csr_wb_esubcode are 0.
- FSM states:
  - IDLE: on take_ex, latch redirect_pc <= csr_eentry and go to REDIR. On take_ertn, latch redirect_pc <= csr_era and go to REDIR.
  - REDIR: redirect_valid=1. Go to IDLE on redirect_ready.
- pipe_flush = take_ex | take_ertn | (state==REDIR). In REDIR, wb_valid, interrupts and exceptions are ignored, so no strobes are issued.
- ex_count increments by 1 on each take_ex and wraps at 2^CNT_W.

## Timing
- Reset values of the outputs:
  - state = IDLE
  - redirect_valid = 0
  - redirect_pc = 0
  - ex_count = 0
  - All strobes are 0 and pipe_flush is 0 when wb_valid=0.
- Detection to strobe: 0 cycles (combinational).
- Detection to redirect_valid: 1 cycle.
- redirect_valid and redirect_pc stay stable until the cycle in which redirect_ready=1. redirect_valid is low in the following cycle.
- Minimum spacing between two taken events: 2 cycles, one detection cycle plus one REDIR cycle.
- redirect_pc latches csr_eentry/csr_era as they are before the edge. A CSR write on the same edge does not affect this transaction.
- An interrupt asserting while in REDIR stays pending in ESTAT. It is taken on the first IDLE cycle with wb_valid.
- Reset in REDIR forces IDLE and drops redirect_valid on the next edge. The redirect is lost.
- redirect_ready while in IDLE is ignored.

## Test plan
- Syscall: EENTRY=0x1c008000, wb_valid=1, wb_ex_vec=SYS, wb_pc=0x1c000100.
  - Same cycle: csr_wb_ex=1, ecode=0x0B, csr_wb_pc=0x1c000100, pipe_flush=1.
  - Next cycle: redirect_valid=1, redirect_pc=0x1c008000.
  - With redirect_ready held 0 for 3 cycles, everything is held. ex_count=1.
- ertn: ERA=0x1c000104, wb_ertn=1.
  - Same cycle: csr_ertn_flush=1, csr_wb_ex=0.
  - redirect_pc=0x1c000104, and the FSM returns to IDLE when redirect_ready=1.
- Priority: wb_ex_vec={ADEF,ALE} and wb_ertn=1 give ecode 0x08 with csr_ertn_flush=0.
  - Adding IS[11]=1, LIE[11]=1, IE=1 gives ecode 0x00.
  - With IE=0 and IS[11]=1, no interrupt is taken; the exceptions still are.
- Timer interrupt: IS[11]=1, LIE[11]=1, IE=1, and wb_valid asserts with no flags at wb_pc=0x1c000200.
  - csr_wb_ex=1, ecode=0, csr_wb_pc=0x1c000200.
- Blocking and counter wrap: during REDIR, apply wb_valid with SYS for 2 cycles → no csr_wb_ex.
  - With CNT_W=4, 16 taken exceptions return ex_count to 0.
- Reset in REDIR: assert reset → redirect_valid=0 and state IDLE the next cycle.
  - A new BRK right after reset gives ecode 0x0C normally.

Source files
------------

// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer between write-back and the CSR file: prioritises the
// committing instruction's events, strobes the CSR file and holds a redirect for fetch.
module excp_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_vaddr,
    input  logic [4:0]       wb_ex_vec,
    input  logic             wb_ertn,
    input  logic [12:0]      csr_estat_is,
    input  logic [12:0]      csr_ecfg_lie,
    input  logic             csr_crmd_ie,
    input  logic [31:0]      csr_eentry,
    input  logic [31:0]      csr_era,
    input  logic             redirect_ready,
    output logic             csr_wb_ex,
    output logic [5:0]       csr_wb_ecode,
    output logic [8:0]       csr_wb_esubcode,
    output logic [31:0]      csr_wb_pc,
    output logic [31:0]      csr_wb_vaddr,
    output logic             csr_ertn_flush,
    output logic             pipe_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] ex_count
);

    localparam int EX_ADEF = 4;
    localparam int EX_INE  = 3;
    localparam int EX_SYS  = 2;
    localparam int EX_BRK  = 1;
    localparam int EX_ALE  = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {
        IDLE,
        REDIR
    } state_t;

    state_t     state;
    logic       int_pend;
    logic       any_ex;
    logic       take_ex;
    logic       take_ertn;
    logic [5:0] ecode;

    // Events are only recognised in IDLE; while a redirect is outstanding the
    // write-back contents are stale and any interrupt simply stays pending.
    always_comb begin
        int_pend  = (|(csr_estat_is & csr_ecfg_lie)) & csr_crmd_ie;
        any_ex    = |wb_ex_vec;
        take_ex   = (state == IDLE) && wb_valid && (int_pend || any_ex);
        take_ertn = (state == IDLE) && wb_valid && wb_ertn && !take_ex;
    end

    always_comb begin
        ecode = ECODE_INT;
        if (take_ex) begin
            if (int_pend)                    ecode = ECODE_INT;
            else if (wb_ex_vec[EX_ADEF])     ecode = ECODE_ADEF;
            else if (wb_ex_vec[EX_INE])      ecode = ECODE_INE;
            else if (wb_ex_vec[EX_SYS])      ecode = ECODE_SYS;
            else if (wb_ex_vec[EX_BRK])      ecode = ECODE_BRK;
            else if (wb_ex_vec[EX_ALE])      ecode = ECODE_ALE;
        end
    end

    assign csr_wb_ex       = take_ex;
    assign csr_ertn_flush  = take_ertn;
    assign csr_wb_ecode    = ecode;
    assign csr_wb_esubcode = 9'd0;
    assign csr_wb_pc       = wb_pc;
    assign csr_wb_vaddr    = wb_vaddr;
    assign pipe_flush      = take_ex || take_ertn || (state == REDIR);

    // The target is captured from the CSR values seen before the edge, so a CSR
    // write landing on the same edge cannot disturb the redirect in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            ex_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_ex) begin
                        redirect_pc    <= csr_eentry;
                        redirect_valid <= 1'b1;
                        ex_count       <= ex_count + CNT_W'(1);
                        state          <= REDIR;
                    end else if (take_ertn) begin
                        redirect_pc    <= csr_era;
                        redirect_valid <= 1'b1;
                        state          <= REDIR;
                    end
                end
                REDIR: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl with a 4-bit counter so that wrap-around is reachable.
module tb_excp_ctrl;

    localparam int CNT_W = 4;

    localparam logic [4:0] V_NONE = 5'b00000;
    localparam logic [4:0] V_ADEF = 5'b10000;
    localparam logic [4:0] V_SYS  = 5'b00100;
    localparam logic [4:0] V_BRK  = 5'b00010;
    localparam logic [4:0] V_ALE  = 5'b00001;

    logic             clk;
    logic             reset;
    logic             wb_valid;
    logic [31:0]      wb_pc;
    logic [31:0]      wb_vaddr;
    logic [4:0]       wb_ex_vec;
    logic             wb_ertn;
    logic [12:0]      csr_estat_is;
    logic [12:0]      csr_ecfg_lie;
    logic             csr_crmd_ie;
    logic [31:0]      csr_eentry;
    logic [31:0]      csr_era;
    logic             redirect_ready;
    logic             csr_wb_ex;
    logic [5:0]       csr_wb_ecode;
    logic [8:0]       csr_wb_esubcode;
    logic [31:0]      csr_wb_pc;
    logic [31:0]      csr_wb_vaddr;
    logic             csr_ertn_flush;
    logic             pipe_flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] ex_count;

    int               num_checks;
    int               num_errors;
    logic [CNT_W-1:0] exp_count;

    excp_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_valid        (wb_valid),
        .wb_pc           (wb_pc),
        .wb_vaddr        (wb_vaddr),
        .wb_ex_vec       (wb_ex_vec),
        .wb_ertn         (wb_ertn),
        .csr_estat_is    (csr_estat_is),
        .csr_ecfg_lie    (csr_ecfg_lie),
        .csr_crmd_ie     (csr_crmd_ie),
        .csr_eentry      (csr_eentry),
        .csr_era         (csr_era),
        .redirect_ready  (redirect_ready),
        .csr_wb_ex       (csr_wb_ex),
        .csr_wb_ecode    (csr_wb_ecode),
        .csr_wb_esubcode (csr_wb_esubcode),
        .csr_wb_pc       (csr_wb_pc),
        .csr_wb_vaddr    (csr_wb_vaddr),
        .csr_ertn_flush  (csr_ertn_flush),
        .pipe_flush      (pipe_flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .ex_count        (ex_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a further settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] vec, input logic ertn, input logic [31:0] pc);
        wb_valid  = valid;
        wb_ex_vec = vec;
        wb_ertn   = ertn;
        wb_pc     = pc;
        #1;
    endtask

    task automatic finishRedirect();
        applyStimulus(1'b0, V_NONE, 1'b0, 32'h0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        #1;
        checkOutput("redirect_dropped", 32'(redirect_valid), 32'd0);
    endtask

    task automatic takeSyscall();
        applyStimulus(1'b1, V_SYS, 1'b0, 32'h1c000300);
        checkOutput("loop_ex_strobe", 32'(csr_wb_ex), 32'd1);
        tick();
        exp_count = exp_count + 4'd1;
        finishRedirect();
    endtask

    initial begin
        logic [4:0] prio_vec [4];
        logic [5:0] prio_code [4];

        num_checks     = 0;
        num_errors     = 0;
        exp_count      = '0;
        reset          = 1'b1;
        wb_valid       = 1'b0;
        wb_pc          = 32'h0;
        wb_vaddr       = 32'h0;
        wb_ex_vec      = V_NONE;
        wb_ertn        = 1'b0;
        csr_estat_is   = 13'h0;
        csr_ecfg_lie   = 13'h0;
        csr_crmd_ie    = 1'b0;
        csr_eentry     = 32'h1c008000;
        csr_era        = 32'h0;
        redirect_ready = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
        checkOutput("rst_ex_count", 32'(ex_count), 32'd0);
        checkOutput("rst_pipe_flush", 32'(pipe_flush), 32'd0);
        checkOutput("rst_wb_ex", 32'(csr_wb_ex), 32'd0);

        // Syscall
        wb_vaddr = 32'h12345678;
        applyStimulus(1'b1, V_SYS, 1'b0, 32'h1c000100);
        checkOutput("sys_wb_ex", 32'(csr_wb_ex), 32'd1);
        checkOutput("sys_ecode", 32'(csr_wb_ecode), 32'h0B);
        checkOutput("sys_esubcode", 32'(csr_wb_esubcode), 32'd0);
        checkOutput("sys_wb_pc", csr_wb_pc, 32'h1c000100);
        checkOutput("sys_wb_vaddr", csr_wb_vaddr, 32'h12345678);
        checkOutput("sys_pipe_flush", 32'(pipe_flush), 32'd1);
        checkOutput("sys_no_redirect_yet", 32'(redirect_valid), 32'd0);
        tick();
        exp_count = exp_count + 4'd1;
        csr_eentry = 32'h1c00a000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, V_SYS, 1'b0, 32'h1c000104);
            checkOutput("hold_redirect_valid", 32'(redirect_valid), 32'd1);
            checkOutput("hold_redirect_pc", redirect_pc, 32'h1c008000);
            checkOutput("hold_ex_count", 32'(ex_count), 32'(exp_count));
            checkOutput("hold_blocked_ex", 32'(csr_wb_ex), 32'd0);
            checkOutput("hold_pipe_flush", 32'(pipe_flush), 32'd1);
            tick();
        end
        redirect_ready = 1'b1;
        applyStimulus(1'b0, V_NONE, 1'b0, 32'h0);
        checkOutput("accept_cycle_valid", 32'(redirect_valid), 32'd1);
        tick();
        redirect_ready = 1'b0;
        #1;
        checkOutput("after_accept_valid", 32'(redirect_valid), 32'd0);
        checkOutput("after_accept_flush", 32'(pipe_flush), 32'd0);

        // redirect_ready in IDLE does nothing
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        #1;
        checkOutput("idle_ready_ignored", 32'(redirect_valid), 32'd0);

        // ertn
        csr_era = 32'h1c000104;
        applyStimulus(1'b1, V_NONE, 1'b1, 32'h1c000400);
        checkOutput("ertn_flush", 32'(csr_ertn_flush), 32'd1);
        checkOutput("ertn_no_ex", 32'(csr_wb_ex), 32'd0);
        checkOutput("ertn_ecode", 32'(csr_wb_ecode), 32'd0);
        checkOutput("ertn_pipe_flush", 32'(pipe_flush), 32'd1);
        tick();
        csr_era = 32'hdeadbeef;
        applyStimulus(1'b0, V_NONE, 1'b0, 32'h0);
        checkOutput("ertn_redirect_valid", 32'(redirect_valid), 32'd1);
        checkOutput("ertn_redirect_pc", redirect_pc, 32'h1c000104);
        checkOutput("ertn_count_same", 32'(ex_count), 32'(exp_count));
        finishRedirect();

        // Priority
        csr_eentry = 32'h1c008000;
        applyStimulus(1'b1, V_ADEF | V_ALE, 1'b1, 32'h1c000500);
        checkOutput("prio_adef_ecode", 32'(csr_wb_ecode), 32'h08);
        checkOutput("prio_ertn_loses", 32'(csr_ertn_flush), 32'd0);
        checkOutput("prio_adef_ex", 32'(csr_wb_ex), 32'd1);
        csr_estat_is = 13'h800;
        csr_ecfg_lie = 13'h800;
        csr_crmd_ie  = 1'b1;
        #1;
        checkOutput("prio_int_ecode", 32'(csr_wb_ecode), 32'h00);
        checkOutput("prio_int_ex", 32'(csr_wb_ex), 32'd1);
        csr_crmd_ie = 1'b0;
        #1;
        checkOutput("prio_ie0_ecode", 32'(csr_wb_ecode), 32'h08);
        checkOutput("prio_ie0_ex", 32'(csr_wb_ex), 32'd1);
        csr_estat_is = 13'h0;
        csr_ecfg_lie = 13'h0;
        wb_ertn = 1'b0;

        prio_vec[0] = 5'b01111; prio_code[0] = 6'h0D;
        prio_vec[1] = 5'b00111; prio_code[1] = 6'h0B;
        prio_vec[2] = 5'b00011; prio_code[2] = 6'h0C;
        prio_vec[3] = 5'b00001; prio_code[3] = 6'h09;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, prio_vec[i], 1'b0, 32'h1c000500);
            checkOutput("prio_table_ecode", 32'(csr_wb_ecode), 32'(prio_code[i]));
        end
        applyStimulus(1'b1, V_ADEF | V_ALE, 1'b0, 32'h1c000500);
        tick();
        exp_count = exp_count + 4'd1;
        applyStimulus(1'b0, V_NONE, 1'b0, 32'h0);
        checkOutput("prio_redirect_pc", redirect_pc, 32'h1c008000);
        checkOutput("prio_ex_count", 32'(ex_count), 32'(exp_count));
        finishRedirect();

        // No strobes without wb_valid
        applyStimulus(1'b0, V_SYS, 1'b1, 32'h1c000600);
        checkOutput("novalid_ex", 32'(csr_wb_ex), 32'd0);
        checkOutput("novalid_ertn", 32'(csr_ertn_flush), 32'd0);
        checkOutput("novalid_flush", 32'(pipe_flush), 32'd0);

        // Timer interrupt, then one that stays pending through REDIR
        csr_eentry   = 32'h1c00c000;
        csr_estat_is = 13'h800;
        csr_ecfg_lie = 13'h800;
        csr_crmd_ie  = 1'b1;
        applyStimulus(1'b1, V_NONE, 1'b0, 32'h1c000200);
        checkOutput("tmr_ex", 32'(csr_wb_ex), 32'd1);
        checkOutput("tmr_ecode", 32'(csr_wb_ecode), 32'h00);
        checkOutput("tmr_wb_pc", csr_wb_pc, 32'h1c000200);
        tick();
        exp_count = exp_count + 4'd1;
        applyStimulus(1'b1, V_NONE, 1'b0, 32'h1c000204);
        checkOutput("tmr_redir_blocked", 32'(csr_wb_ex), 32'd0);
        checkOutput("tmr_redirect_pc", redirect_pc, 32'h1c00c000);
        finishRedirect();
        checkOutput("tmr_pending_novalid", 32'(csr_wb_ex), 32'd0);
        applyStimulus(1'b1, V_NONE, 1'b0, 32'h1c000204);
        checkOutput("tmr_pending_taken", 32'(csr_wb_ex), 32'd1);
        tick();
        exp_count = exp_count + 4'd1;
        finishRedirect();
        csr_estat_is = 13'h0;
        csr_ecfg_lie = 13'h0;
        csr_crmd_ie  = 1'b0;

        // Counter wrap
        while (exp_count != 4'd15) takeSyscall();
        checkOutput("count_before_wrap", 32'(ex_count), 32'd15);
        takeSyscall();
        checkOutput("count_wrapped", 32'(ex_count), 32'd0);

        // Reset while in REDIR
        applyStimulus(1'b1, V_SYS, 1'b0, 32'h1c000700);
        tick();
        applyStimulus(1'b0, V_NONE, 1'b0, 32'h0);
        checkOutput("pre_rst_redirect", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = '0;
        #1;
        checkOutput("redir_rst_valid", 32'(redirect_valid), 32'd0);
        checkOutput("redir_rst_pc", redirect_pc, 32'h0);
        checkOutput("redir_rst_count", 32'(ex_count), 32'd0);
        checkOutput("redir_rst_flush", 32'(pipe_flush), 32'd0);
        applyStimulus(1'b1, V_BRK, 1'b0, 32'h1c000800);
        checkOutput("brk_ex", 32'(csr_wb_ex), 32'd1);
        checkOutput("brk_ecode", 32'(csr_wb_ecode), 32'h0C);
        tick();
        exp_count = exp_count + 4'd1;
        applyStimulus(1'b0, V_NONE, 1'b0, 32'h0);
        checkOutput("brk_redirect", 32'(redirect_valid), 32'd1);
        checkOutput("brk_count", 32'(ex_count), 32'(exp_count));
        finishRedirect();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
